// File: rtl/powlib_afifo_rd_pkg.sv
// Shared helpers for the async FIFO read side: ceil-log2 and gray encode/decode.
// Gray helpers work on a fixed 32-bit container; callers size-cast in and out.
package powlib_afifo_rd_pkg;

   localparam int GRAYW = 32;

   typedef logic [GRAYW-1:0] gray_t;

   function automatic int clogb2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

   function automatic gray_t grayencode(input gray_t b);
      return b ^ (b >> 1);
   endfunction

   function automatic gray_t graydecode(input gray_t g);
      gray_t b;
      b[GRAYW-1] = g[GRAYW-1];
      for (int i = GRAYW-2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/powlib_afifo_rd_wptrsync.sv
// Brings the write domain's gray pointer into clk through S flop stages and
// decodes it to binary; adds S cycles of latency.
module powlib_afifo_wptrsync
   import powlib_afifo_rd_pkg::*;
#(
   parameter int WIDX = 3,
   parameter int S    = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [WIDX:0] wrptr_gray,
   output logic [WIDX:0] wbin
);

   logic [S:0][WIDX:0] stg;

   assign stg[0] = wrptr_gray;

   genvar i;
   generate
      for (i = 0; i < S; i++) begin : g_stage
         powlib_flipflop #(.W(WIDX+1), .EAR(1'b1)) u_ff (
            .clk (clk),
            .rst (rst),
            .vld (1'b1),
            .d   (stg[i]),
            .q   (stg[i+1])
         );
      end
   endgenerate

   // Only the last stage is decoded; earlier stages may be metastable.
   assign wbin = (WIDX+1)'(graydecode(gray_t'(stg[S])));

endmodule

// File: rtl/powlib_flipflop.sv
// Enabled register with configurable reset value; EAR selects asynchronous
// active-low reset, otherwise reset is sampled on clk.
module powlib_flipflop #(
   parameter int           W    = 1,
   parameter logic [W-1:0] INIT = '0,
   parameter bit           EAR  = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         vld,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   generate
      if (EAR) begin : g_async
         always_ff @(posedge clk or negedge rst) begin
            if (!rst)     q <= INIT;
            else if (vld) q <= d;
         end
      end else begin : g_sync
         always_ff @(posedge clk) begin
            if (!rst)     q <= INIT;
            else if (vld) q <= d;
         end
      end
   endgenerate

endmodule

// File: rtl/powlib_afifo_rd.sv
// Read side of an async FIFO: registered output word with valid/ready, one word
// per cycle under rdrdy; rddata holds while rdvld && !rdrdy.
module powlib_afifo_rd
   import powlib_afifo_rd_pkg::*;
#(
   parameter int W    = 32,
   parameter int D    = 8,
   parameter int WIDX = clogb2(D),
   parameter int S    = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [WIDX:0] wrptr_gray,
   output logic [WIDX:0] rdptr_gray,
   output logic [WIDX-1:0] rdidx,
   input  logic [W-1:0]  memdata,
   output logic [W-1:0]  rddata,
   output logic          rdvld,
   input  logic          rdrdy,
   output logic          empty,
   output logic [WIDX:0] level
);

   logic [WIDX:0] wbin;
   logic [WIDX:0] rbin;
   logic [WIDX:0] rbin_nxt;
   logic [WIDX:0] rgray_nxt;
   logic          load;
   logic          rdvld_nxt;

   powlib_afifo_wptrsync #(.WIDX(WIDX), .S(S)) u_wptrsync (
      .clk        (clk),
      .rst        (rst),
      .wrptr_gray (wrptr_gray),
      .wbin       (wbin)
   );

   assign rdidx     = rbin[WIDX-1:0];
   assign empty     = (rbin == wbin);
   assign level     = wbin - rbin;
   // Refill the output register whenever it is free or being consumed this edge.
   assign load      = !empty && (!rdvld || rdrdy);
   assign rbin_nxt  = rbin + (WIDX+1)'(1);
   assign rgray_nxt = (WIDX+1)'(grayencode(gray_t'(rbin_nxt)));
   assign rdvld_nxt = load || (rdvld && !rdrdy);

   powlib_flipflop #(.W(WIDX+1), .EAR(1'b1)) u_rbin (
      .clk (clk),
      .rst (rst),
      .vld (load),
      .d   (rbin_nxt),
      .q   (rbin)
   );

   powlib_flipflop #(.W(WIDX+1), .EAR(1'b1)) u_rgray (
      .clk (clk),
      .rst (rst),
      .vld (load),
      .d   (rgray_nxt),
      .q   (rdptr_gray)
   );

   powlib_flipflop #(.W(W), .EAR(1'b1)) u_rddata (
      .clk (clk),
      .rst (rst),
      .vld (load),
      .d   (memdata),
      .q   (rddata)
   );

   powlib_flipflop #(.W(1), .EAR(1'b1)) u_rdvld (
      .clk (clk),
      .rst (rst),
      .vld (1'b1),
      .d   (rdvld_nxt),
      .q   (rdvld)
   );

endmodule

// File: tb/tb_powlib_afifo_rd.sv
// Bench for powlib_afifo_rd (D=8, S=2): emulated write domain plus data/index scoreboard.
module tb_powlib_afifo_rd;

   localparam int W    = 32;
   localparam int D    = 8;
   localparam int WIDX = 3;
   localparam int S    = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic [WIDX:0]   wrptr_gray;
   logic [WIDX:0]   rdptr_gray;
   logic [WIDX-1:0] rdidx;
   logic [W-1:0]    memdata;
   logic [W-1:0]    rddata;
   logic            rdvld;
   logic            rdrdy;
   logic            empty;
   logic [WIDX:0]   level;

   logic [W-1:0]    mem [D];
   logic [W-1:0]    sb [$];
   logic [WIDX-1:0] iq [$];
   logic [WIDX:0]   wp;
   logic [WIDX:0]   prev_gray;
   int              nchk = 0;
   int              nerr = 0;
   int              nread = 0;
   int              n0;

   always #5 clk = ~clk;

   assign memdata = mem[rdidx];

   powlib_afifo_rd #(.W(W), .D(D), .WIDX(WIDX), .S(S)) dut (
      .clk        (clk),
      .rst        (rst),
      .wrptr_gray (wrptr_gray),
      .rdptr_gray (rdptr_gray),
      .rdidx      (rdidx),
      .memdata    (memdata),
      .rddata     (rddata),
      .rdvld      (rdvld),
      .rdrdy      (rdrdy),
      .empty      (empty),
      .level      (level)
   );

   function automatic logic [WIDX:0] g(input logic [WIDX:0] b);
      return b ^ (b >> 1);
   endfunction

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic push(input logic [W-1:0] v);
      mem[wp[WIDX-1:0]] = v;
      sb.push_back(v);
      iq.push_back(wp[WIDX-1:0]);
      wp = wp + 1'b1;
      wrptr_gray = g(wp);
   endtask

   task automatic push_rand(input int n);
      for (int i = 0; i < n; i++) push($urandom);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      sb.delete();
      iq.delete();
      wp = '0;
      wrptr_gray = '0;
      rdrdy = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
   endtask

   task automatic drain(input int maxc);
      int c;
      rdrdy = 1'b1;
      c = 0;
      while (!(empty && !rdvld && sb.size() == 0) && c < maxc) begin
         @(posedge clk); #1;
         c++;
      end
      if (c >= maxc) check("drain_timeout", 0, 1);
   endtask

   // Monitor: handshake and load decisions are stable at the falling edge.
   always @(negedge clk) begin
      if (rst === 1'b1) begin
         if (rdvld && rdrdy) begin
            if (sb.size() == 0) check("sb_underflow", 1, 0);
            else begin
               check("data", rddata, sb.pop_front());
               nread++;
            end
         end
         if (!empty && (!rdvld || rdrdy)) begin
            if (iq.size() == 0) check("idx_extra", 1, 0);
            else check("rdidx", rdidx, iq.pop_front());
         end
         if (rdptr_gray != prev_gray) check("gray_step", $countones(rdptr_gray ^ prev_gray), 1);
      end
      prev_gray = rdptr_gray;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0;
      wrptr_gray = '0;
      rdrdy = 1'b0;
      wp = '0;
      prev_gray = '0;
      for (int i = 0; i < D; i++) mem[i] = '0;
      #3;
      check("rst_empty", empty, 1);
      check("rst_rdvld", rdvld, 0);
      check("rst_rdptr", rdptr_gray, 0);
      check("rst_level", level, 0);
      check("rst_rddata", rddata, 0);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1;

      // Three words, consumer always ready: latency and back-to-back output.
      rdrdy = 1'b1;
      push(32'hAAAA_0001);
      push(32'hBBBB_0002);
      push(32'hCCCC_0003);
      @(posedge clk); #1 check("lat_e1_empty", empty, 1);
      @(posedge clk); #1 check("lat_e2_empty", empty, 0);
      check("lat_e2_level", level, 3);
      check("lat_e2_rdvld", rdvld, 0);
      @(posedge clk); #1 check("seq_a_vld", rdvld, 1);
      check("seq_a", rddata, 32'hAAAA_0001);
      @(posedge clk); #1 check("seq_b", rddata, 32'hBBBB_0002);
      @(posedge clk); #1 check("seq_c", rddata, 32'hCCCC_0003);
      check("seq_c_vld", rdvld, 1);
      @(posedge clk); #1 check("seq_end_vld", rdvld, 0);
      check("seq_end_rdptr", rdptr_gray, g(4'd3));
      check("seq_end_empty", empty, 1);
      check("seq_end_level", level, 0);

      // Backpressure with four entries.
      do_reset();
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) push(32'h1000 + i);
      repeat (4) @(posedge clk); #1;
      check("bp_vld", rdvld, 1);
      check("bp_data", rddata, 32'h1000);
      check("bp_level", level, 3);
      check("bp_rdptr", rdptr_gray, g(4'd1));
      @(posedge clk); #1 check("bp_hold", rddata, 32'h1000);
      check("bp_hold_rdptr", rdptr_gray, g(4'd1));
      n0 = nread;
      rdrdy = 1'b1;
      repeat (3) @(posedge clk); #1 check("bp_drain3_vld", rdvld, 1);
      @(posedge clk); #1 check("bp_drain4_vld", rdvld, 0);
      check("bp_drain_count", nread - n0, 4);
      check("bp_drain_empty", empty, 1);

      // Advance pointers to rbin=14, then read across the wrap.
      push_rand(5);
      drain(40);
      push_rand(5);
      drain(40);
      check("wrap_pre_rdptr", rdptr_gray, g(4'd14));
      push_rand(4);
      @(posedge clk); #1;
      @(posedge clk); #1 check("wrap_level", level, 4);
      n0 = nread;
      drain(40);
      check("wrap_count", nread - n0, 4);
      check("wrap_rdptr", rdptr_gray, g(4'd2));
      check("wrap_idx", rdidx, 2);
      check("wrap_level_end", level, 0);

      // Full memory: eight entries, read in order.
      do_reset();
      @(posedge clk); #1;
      for (int i = 0; i < 8; i++) push(32'h8000 + i);
      @(posedge clk); #1;
      @(posedge clk); #1 check("full_level", level, 8);
      check("full_empty", empty, 0);
      n0 = nread;
      drain(40);
      check("full_count", nread - n0, 8);
      check("full_empty_end", empty, 1);
      check("full_rdptr", rdptr_gray, g(4'd8));

      // Asynchronous reset while a word is being presented.
      rdrdy = 1'b0;
      push_rand(4);
      repeat (4) @(posedge clk); #1;
      check("ar_pre_vld", rdvld, 1);
      #2 rst = 1'b0;
      #1;
      check("ar_vld", rdvld, 0);
      check("ar_rdptr", rdptr_gray, 0);
      check("ar_rddata", rddata, 0);
      sb.delete();
      iq.delete();
      wp = '0;
      wrptr_gray = '0;
      @(posedge clk); #1;
      check("ar_empty", empty, 1);
      check("ar_level", level, 0);
      rst = 1'b1;
      @(posedge clk); #1;
      push(32'h5A5A_0000);
      n0 = nread;
      drain(40);
      check("ar_recover", nread - n0, 1);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/powlib_afifo_rd.md
POWLIB_AFIFO_RD -- requirements
Module: powlib_afifo_rd

Interface
REQ-001 SHALL have parameter W, default 32, data width.
REQ-002 SHALL have parameter D, default 8, FIFO depth, power of two, at least 2.
REQ-003 SHALL have parameter WIDX, default clog2(D), dpram index width.
REQ-004 SHALL have parameter S, default 2, write-pointer synchronizer stages, at least 2.
REQ-005 SHALL have port clk  input  1  read-domain clock.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port wrptr_gray  input  WIDX+1  gray-coded write pointer from the write domain (asynchronous to clk).
REQ-008 SHALL have port rdptr_gray  output  WIDX+1  registered gray-coded read pointer to the write domain.
REQ-009 SHALL have port rdidx  output  WIDX  dpram read index.
REQ-010 SHALL have port memdata  input  W  dpram combinational read data at rdidx.
REQ-011 SHALL have port rddata  output  W  registered output data.
REQ-012 SHALL have port rdvld  output  1  rddata valid.
REQ-013 SHALL have port rdrdy  input  1  consumer ready.
REQ-014 SHALL have port empty  output  1  no unread entries in memory.
REQ-015 SHALL have port level  output  WIDX+1  number of synchronized entries not yet loaded into the output register.

Function
REQ-016 SHALL pass wrptr_gray through S clk flops, then gray-decode to the binary pointer wbin.
REQ-017 SHALL hold binary read pointer rbin, WIDX+1 bits, wrapping 2D-1 -> 0.
REQ-018 SHALL drive rdidx = rbin[WIDX-1:0] combinationally.
REQ-019 SHALL drive empty = (rbin == wbin) combinationally; level = (wbin - rbin) mod 2^(WIDX+1).
REQ-020 SHALL define the load condition as !empty && (!rdvld || rdrdy).
REQ-021 SHALL, on a load edge, capture memdata into rddata, set rdvld=1, increment rbin, and register gray(rbin+1) into rdptr_gray.
REQ-022 SHALL, when rdvld && rdrdy && empty, clear rdvld and hold rddata.
REQ-023 SHALL hold rddata stable while rdvld && !rdrdy; rdptr SHALL NOT advance.
REQ-024 SHALL sustain one word per cycle when rdrdy=1 and level >= 1 (no bubbles).
REQ-025 SHALL have latency: wrptr_gray change -> empty falls after S edges -> rdvld rises on the next edge.
REQ-026 SHALL never advance rbin past wbin (no underflow), including across pointer wrap.
REQ-027 SHALL change rdptr_gray by exactly one bit per increment.

Reset
REQ-028 SHALL, while rst=0, asynchronously force rbin=0, rdptr_gray=0, rdvld=0, rddata=0, and all synchronizer flops to 0 (so empty=1, level=0).
REQ-029 SHALL, on reset mid-transfer, discard the output word; the write domain is reset concurrently by system convention.

Structure
REQ-030 SHALL use the shared powlib_std.vh clogb2, grayencode and graydecode functions; no new shared constants.
REQ-031 SHALL build flops from powlib_flipflop with EAR=1; the synchronizer SHALL be powlib_ffsync-style, S stages.
REQ-032 SHALL place pointer synchronization and decode in one sub-module, powlib_afifo_wptrsync (gray in, binary out).

Verification
REQ-033 SHALL cover: reset, then wrptr_gray=0 -> empty=1, rdvld=0, rdptr_gray=0, level=0.
REQ-034 SHALL cover (D=8, S=2): wrptr_gray=gray(3), memory holding A,B,C, rdrdy=1 -> empty=0 after 2 edges; rddata=A,B,C on 3 consecutive cycles; then rdvld=0, rdptr_gray=gray(3).
REQ-035 SHALL cover backpressure: rdrdy=0 with 4 entries -> after 1 load, rddata=word0 held, level=3, rdptr_gray=gray(1); rdrdy=1 -> drain in 4 cycles.
REQ-036 SHALL cover wrap: rbin=14, wbin=2 (level=4) -> reads indices 6,7,0,1; rbin ends at 2, rdptr_gray=gray(2).
REQ-037 SHALL cover full: wbin=8, rbin=0 -> level=8; 8 words read in order, then empty=1.
REQ-038 SHALL cover asynchronous reset with rst=0 mid-stream while rdvld=1 -> rdvld=0 and rdptr_gray=0 immediately, without a clk edge.
